// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types for the Nibbler data-bus arbiters.
package nibbler_bus_pkg;

   typedef enum logic [1:0] {
      BUS_IDLE,
      BUS_DRIVE,
      BUS_TURN
   } bus_state_t;

   localparam int CONTENTION_CNT_WIDTH = 8;

endpackage

// File: rtl/tristate_bus_arbiter_pick.sv
// Lowest-index-wins one-hot request selector, shared by the Nibbler bus arbiters.
module bus_priority_pick #(
   parameter int CHANNELS = 4
) (
   input  logic [CHANNELS-1:0] req_i,
   output logic [CHANNELS-1:0] pick_o,
   output logic                any_o
);

   // Scan from the top down so that the lowest set index is the last one written.
   always_comb begin
      pick_o = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            pick_o    = '0;
            pick_o[i] = 1'b1;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Fixed-priority, non-preemptive arbiter driving one shared tristate bus with a Z turnaround gap.
// Optional saturating contention counter enabled by TRISTATE_BUS_CONTENTION_CNT_EN.
module tristate_bus_arbiter
   import nibbler_bus_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int CHANNELS   = 4,
   parameter int TURNAROUND = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [CHANNELS*WIDTH-1:0]       dataIn,
   input  logic [CHANNELS-1:0]             enableN,
   output logic [WIDTH-1:0]                dataOut,
   output logic [CHANNELS-1:0]             grant,
   output logic                            busy,
   output logic                            contention,
   output logic [CONTENTION_CNT_WIDTH-1:0] contentionCount
);

   localparam int TCW       = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;
   localparam int TURN_LOAD = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;

   bus_state_t          state_q;
   logic [CHANNELS-1:0] grant_q;
   logic [TCW-1:0]      turnCnt_q;
   logic                contention_q;

   logic [CHANNELS-1:0] req;
   logic [CHANNELS-1:0] pick;
   logic                anyReq;
   logic                ownerReq;
   logic                multiReq;
   logic [WIDTH-1:0]    ownerData;

   assign req      = ~enableN;
   assign ownerReq = |(grant_q & req);
   assign multiReq = ($countones(req) > 1);

   bus_priority_pick #(
      .CHANNELS(CHANNELS)
   ) u_pick (
      .req_i (req),
      .pick_o(pick),
      .any_o (anyReq)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= BUS_IDLE;
         grant_q      <= '0;
         turnCnt_q    <= '0;
         contention_q <= 1'b0;
      end else begin
         contention_q <= multiReq;
         case (state_q)
            BUS_IDLE: begin
               if (anyReq) begin
                  state_q <= BUS_DRIVE;
                  grant_q <= pick;
               end
            end
            BUS_DRIVE: begin
               // With the owner gone, req holds only the other requesters.
               if (!ownerReq) begin
                  if (!anyReq) begin
                     state_q <= BUS_IDLE;
                     grant_q <= '0;
                  end else if (TURNAROUND == 0) begin
                     grant_q <= pick;
                  end else begin
                     state_q   <= BUS_TURN;
                     grant_q   <= '0;
                     turnCnt_q <= TCW'(TURN_LOAD);
                  end
               end
            end
            BUS_TURN: begin
               if (turnCnt_q == '0) begin
                  state_q <= anyReq ? BUS_DRIVE : BUS_IDLE;
                  grant_q <= pick;
               end else begin
                  turnCnt_q <= turnCnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= BUS_IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

   always_comb begin
      ownerData = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant_q[i]) begin
            ownerData = ownerData | dataIn[i*WIDTH +: WIDTH];
         end
      end
   end

   assign dataOut    = (state_q == BUS_DRIVE) ? ownerData : {WIDTH{1'bz}};
   assign grant      = grant_q;
   assign busy       = (state_q != BUS_IDLE);
   assign contention = contention_q;

`ifdef TRISTATE_BUS_CONTENTION_CNT_EN
   logic [CONTENTION_CNT_WIDTH-1:0] cnt_q;
   logic [CONTENTION_CNT_WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (contention_q && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign contentionCount = cnt_q;
`else
   assign contentionCount = '0;
`endif

endmodule
